// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg: shared types, defaults and helpers for the UART queue blocks
package ms_uart_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  typedef enum logic [1:0] {
    Q_IDLE      = 2'b00,
    Q_LAUNCH    = 2'b01,
    Q_WAIT_DONE = 2'b10
  } q_state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/ms_uart_fifo.sv
// ms_uart_fifo: circular byte queue with registered count/flags and sticky overflow
module ms_uart_fifo
  import ms_uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count, w_count_nxt;
  logic r_full, r_empty, r_overflow;
  logic w_pop, w_push, w_drop;
  assign w_pop = i_rd_en && !r_empty;
  assign w_push = i_wr_en && (!r_full || w_pop);
  assign w_drop = i_wr_en && r_full && !w_pop;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_overflow = r_overflow;
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  // pointers, count, registered flags; a dropped push beats a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= w_count_nxt == FULL_CNT;
      r_empty    <= w_count_nxt == '0;
      r_overflow <= w_drop ? 1'b1 : (i_clr_ovf ? 1'b0 : r_overflow);
    end
endmodule

// File: rtl/ms_uart_tx_queue.sv
// ms_uart_tx_queue: buffers host bytes and launches them into the UART transmitter
module ms_uart_tx_queue
  import ms_uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clr_ovf,
  input  logic             i_tx_busy,
  output logic             o_tx_start,
  output logic [WIDTH-1:0] o_tx_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow
);
  q_state_t r_state;
  logic r_tx_start;
  logic [WIDTH-1:0] r_tx_data, w_head;
  logic w_empty, w_pop;
  assign w_pop = (r_state == Q_IDLE) && !w_empty && !i_tx_busy;
  assign o_tx_start = r_tx_start;
  assign o_tx_data = r_tx_data;
  assign o_empty = w_empty;
  ms_uart_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_pop),
    .i_clr_ovf  (i_clr_ovf),
    .o_rd_data  (w_head),
    .o_full     (o_full),
    .o_empty    (w_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );
  // launch FSM: hold START until the transmitter reports busy, then wait for it to finish
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= Q_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        Q_IDLE: if (w_pop) begin
          r_tx_data  <= w_head;
          r_tx_start <= 1'b1;
          r_state    <= Q_LAUNCH;
        end
        Q_LAUNCH: if (i_tx_busy) begin
          r_tx_start <= 1'b0;
          r_state    <= Q_WAIT_DONE;
        end
        Q_WAIT_DONE: if (!i_tx_busy) r_state <= Q_IDLE;
        default: begin
          r_state    <= Q_IDLE;
          r_tx_start <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/ms_uart_tx_queue.md
# ms_uart_tx_queue

Byte queue and launch controller directly upstream of the UART transmitter. It buffers bytes written by the host and feeds them to the transmitter one at a time via its START/BUSY handshake, so the host does not need to poll the transmitter's busy state. It runs on the system clock and tolerates a transmitter that samples START only on slow baud ticks.

## Interface

- DEPTH, 8: queue entries; power of two, 2..64.
- WIDTH, 8: data width; matches the transmitter data input.
- CLK  in  1  system clock; all state changes on rising edge.
- RESETN  in  1  reset, asynchronous assert, active-low; release synchronous to CLK.
- WR_EN  in  1  push WR_DATA this cycle.
- WR_DATA  in  WIDTH  byte to queue.
- CLR_OVF  in  1  clears OVERFLOW.
- TX_BUSY  in  1  transmitter busy, from the transmitter's BUSY output.
- TX_START  out  1  launch request to the transmitter.
- TX_DATA  out  WIDTH  byte being launched; stable from launch until return to IDLE.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  clog2(DEPTH)+1  occupied entries.
- OVERFLOW  out  1  sticky; a push was dropped.

## Operation

- Reset values: TX_START=0, TX_DATA=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, state IDLE, rd/wr pointers 0.
- Queue: circular buffer. Pointers are log2(DEPTH) bits and wrap naturally. COUNT is tracked separately.
- Push: WR_EN && (!FULL || pop this cycle) writes the entry and advances wr_ptr.
- Dropped push: WR_EN && FULL && no pop. Data is discarded, OVERFLOW<=1, and COUNT is unchanged.
- Pop happens only on the IDLE->LAUNCH transition.
- CLR_OVF clears OVERFLOW. If CLR_OVF and a dropped push occur in the same cycle, set wins.
- FSM:
  - IDLE: if !EMPTY && !TX_BUSY, then TX_DATA<=head, pop, TX_START<=1, go to LAUNCH.
  - LAUNCH: hold TX_START=1 and TX_DATA. When TX_BUSY==1, TX_START<=0 and go to WAIT_DONE.
  - WAIT_DONE: when TX_BUSY==0, go to IDLE.
  - Undefined state encodings go to IDLE with TX_START=0.
- No timeout. LAUNCH waits indefinitely for TX_BUSY, as the transmitter may need up to 16 baud ticks plus one frame to raise BUSY.
- Simultaneous push and pop: COUNT is unchanged. A push into an empty queue is not launched in the same cycle; the earliest launch is the next cycle.
- Reset mid-operation: the queue is flushed and TX_START drops immediately (asynchronously). A frame already in flight in the transmitter is not affected.

## Timing

- Push to COUNT/EMPTY/FULL update: 1 cycle (registered flags).
- Push into empty queue with TX idle: TX_START rises at the 2nd rising edge after the WR_EN cycle.
- TX_START falls 1 cycle after TX_BUSY is sampled high.
- Back-to-back bytes: the next launch occurs 2 cycles after TX_BUSY is sampled low (WAIT_DONE->IDLE, then IDLE->LAUNCH).
- Throughput is limited only by the transmitter. Queue overhead is 3 CLK cycles per byte.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package ms_uart_pkg holds:
  - FSM state encodings: Q_IDLE=2'b00, Q_LAUNCH=2'b01, Q_WAIT_DONE=2'b10.
  - Default WIDTH and DEPTH constants.
  - A clog2 helper, reused by the receiver-side queue.
- Sub-module ms_uart_fifo is the storage, pointers, COUNT, flags and overflow logic, reusable on the RX side. The launch FSM lives in the top.

## Test plan

- Push 0xA5 into the empty queue with TX_BUSY=0 -> TX_START=1 and TX_DATA=0xA5 on the 2nd edge; COUNT returns 1->0. Raise TX_BUSY -> TX_START=0 the next cycle.
- Push 0x11, 0x22, 0x33 back-to-back while TX_BUSY=1 -> COUNT=3, no TX_START. Release TX_BUSY, then emulate 3 frames -> launches in order 0x11, 0x22, 0x33, and EMPTY=1 at the end.
- Fill 8 entries with TX_BUSY held high, then push 0xFF -> FULL=1, COUNT=8, OVERFLOW=1, 0xFF never launched. Pulse CLR_OVF -> OVERFLOW=0.
- Queue full and launch pop in the same cycle as a push of 0x5A -> push accepted, COUNT stays 8, 0x5A launched last.
- Assert RESETN=0 while in LAUNCH with COUNT=4 -> TX_START=0 immediately; after release, COUNT=0, EMPTY=1, OVERFLOW=0, TX_DATA=0.
- Hold TX_BUSY=0 for 40 cycles after a launch (slow tick) -> TX_START stays 1 and TX_DATA stays stable until BUSY rises; COUNT unchanged.
